// File: rtl/audio_voice_mixer.sv
// Mixes NUM_VOICES gain-scaled samples per sample_tick through a shared 18x18 multiplier, then shifts and saturates.
// Latency NUM_VOICES*(5 + multiplier busy cycles) + 2; a tick during a frame or while the multiplier is busy only sets overrun.
module audio_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int GAIN_SHIFT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_tick,
    output logic [3:0]         voice_idx,
    input  logic signed [15:0] voice_sample,
    input  logic signed [17:0] voice_gain,
    output logic               mul_start,
    output logic signed [17:0] mul_a,
    output logic signed [17:0] mul_b,
    input  logic signed [35:0] mul_p,
    input  logic               mul_busy,
    output logic signed [15:0] mix_out,
    output logic               mix_valid,
    output logic               overrun
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        ACCUM,
        OUTPUT
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_VOICES - 1);

    state_t              r_state;
    state_t              w_next;
    logic                w_start_frame;
    logic                w_tick_overrun;
    logic [3:0]          r_voice_idx;
    logic signed [39:0]  r_acc;
    logic signed [17:0]  r_mul_a;
    logic signed [17:0]  r_mul_b;
    logic                r_mul_start;
    logic signed [15:0]  r_mix_out;
    logic                r_mix_valid;
    logic                r_overrun;
    logic signed [39:0]  w_shifted;
    logic signed [15:0]  w_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_start_frame  = 1'b0;
        w_tick_overrun = 1'b0;
        case (r_state)
            IDLE: begin
                // A busy multiplier means an operation left over from before reset.
                if (sample_tick) begin
                    if (mul_busy) begin
                        w_tick_overrun = 1'b1;
                    end else begin
                        w_start_frame = 1'b1;
                        w_next        = LOAD;
                    end
                end
            end
            LOAD:    w_next = ISSUE;
            ISSUE:   w_next = WAIT_HI;
            WAIT_HI: if (mul_busy)  w_next = WAIT_LO;
            WAIT_LO: if (!mul_busy) w_next = ACCUM;
            ACCUM:   w_next = (r_voice_idx == LAST_IDX) ? OUTPUT : LOAD;
            OUTPUT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (sample_tick && (r_state != IDLE)) begin
            w_tick_overrun = 1'b1;
        end
    end

    assign w_shifted = r_acc >>> GAIN_SHIFT;

    always_comb begin
        w_sat = w_shifted[15:0];
        if (w_shifted > 40'sd32767) begin
            w_sat = 16'sh7FFF;
        end else if (w_shifted < -40'sd32768) begin
            w_sat = 16'sh8000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_voice_idx <= '0;
            r_acc       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_start <= 1'b0;
            r_mix_out   <= '0;
            r_mix_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_mul_start <= (r_state == LOAD);
            r_mix_valid <= (r_state == OUTPUT);
            if (w_tick_overrun) begin
                r_overrun <= 1'b1;
            end
            // Operands change only here so they stay put while the multiplier reads them.
            case (r_state)
                IDLE: begin
                    if (w_start_frame) begin
                        r_acc       <= '0;
                        r_voice_idx <= '0;
                    end
                end
                LOAD: begin
                    r_mul_a <= {{2{voice_sample[15]}}, voice_sample};
                    r_mul_b <= voice_gain;
                end
                ACCUM: begin
                    r_acc <= r_acc + {{4{mul_p[35]}}, mul_p};
                    if (r_voice_idx != LAST_IDX) begin
                        r_voice_idx <= r_voice_idx + 4'd1;
                    end
                end
                OUTPUT: r_mix_out <= w_sat;
                default: ;
            endcase
        end
    end

    assign voice_idx = r_voice_idx;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mix_out   = r_mix_out;
    assign mix_valid = r_mix_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_audio_voice_mixer.sv
// Bench for audio_voice_mixer: a 5-state multiplier model answers requests and a plain-arithmetic model predicts each mix.
module tb_audio_voice_mixer;

    localparam int NV       = 4;
    localparam int FRAME_LAT = 38;

    logic               clk;
    logic               reset;
    logic               sample_tick;
    logic [3:0]         voice_idx;
    logic signed [15:0] voice_sample;
    logic signed [17:0] voice_gain;
    logic               mul_start;
    logic signed [17:0] mul_a;
    logic signed [17:0] mul_b;
    logic signed [35:0] mul_p = '0;
    logic               mul_busy = 1'b0;
    logic signed [15:0] mix_out;
    logic               mix_valid;
    logic               overrun;

    logic signed [15:0] smp [16];
    logic signed [17:0] gn  [16];

    int n_chk  = 0;
    int n_pass = 0;
    int viol   = 0;
    bit mon_en = 1'b1;

    audio_voice_mixer #(.NUM_VOICES(NV), .GAIN_SHIFT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .voice_idx    (voice_idx),
        .voice_sample (voice_sample),
        .voice_gain   (voice_gain),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_p        (mul_p),
        .mul_busy     (mul_busy),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .overrun      (overrun)
    );

    assign voice_sample = smp[voice_idx];
    assign voice_gain   = gn[voice_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: no reset, busy for 4 cycles starting one cycle after the request,
    // reads mul_a early and mul_b late so unstable operands corrupt the product.
    typedef enum logic [2:0] {M_IDLE, M_HI_A, M_HI_B, M_LO_A, M_LO_B} mstate_t;
    mstate_t            m_st = M_IDLE;
    logic signed [17:0] m_a  = '0;

    always @(posedge clk) begin
        mul_busy <= (m_st != M_IDLE);
        case (m_st)
            M_IDLE: if (mul_start) m_st <= M_HI_A;
            M_HI_A: begin m_a <= mul_a; m_st <= M_HI_B; end
            M_HI_B: m_st <= M_LO_A;
            M_LO_A: m_st <= M_LO_B;
            M_LO_B: begin mul_p <= m_a * mul_b; m_st <= M_IDLE; end
            default: m_st <= M_IDLE;
        endcase
    end

    logic signed [17:0] prev_a = '0;
    logic signed [17:0] prev_b = '0;
    logic               prev_busy = 1'b0;

    always @(negedge clk) begin
        if (mul_start && mul_busy) viol++;
        if (mon_en && mul_busy && prev_busy && ((mul_a != prev_a) || (mul_b != prev_b))) viol++;
        prev_a    = mul_a;
        prev_b    = mul_b;
        prev_busy = mul_busy;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic signed [15:0] ref_mix();
        longint acc;
        acc = 0;
        for (int v = 0; v < NV; v++) acc += longint'(smp[v]) * longint'(gn[v]);
        acc = acc >>> 15;
        if (acc > 32767)  return 16'sh7FFF;
        if (acc < -32768) return 16'sh8000;
        return 16'(acc);
    endfunction

    task automatic rand_voices();
        for (int v = 0; v < NV; v++) begin
            smp[v] = 16'($urandom);
            if ($urandom_range(0, 1) == 1) gn[v] = 18'($urandom);
            else gn[v] = 18'($urandom_range(0, 65536)) - 18'sd32768;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Starts a frame at iteration 0 and optionally a second tick at iteration tick2_at;
    // iteration i observes the state after the i-th rising edge following the tick.
    task automatic run_window(input int tick2_at, input int len, output int pulses,
                              output int first_lat, output logic signed [15:0] out_at_pulse);
        pulses       = 0;
        first_lat    = -1;
        out_at_pulse = '0;
        for (int i = 0; i < len; i++) begin
            sample_tick = (i == 0) || (i == tick2_at);
            if (mix_valid) begin
                pulses++;
                if (first_lat < 0) begin
                    first_lat    = i;
                    out_at_pulse = mix_out;
                end
            end
            @(negedge clk);
        end
        sample_tick = 1'b0;
    endtask

    task automatic do_frame(input string tag, input logic signed [15:0] exp);
        int p, l;
        logic signed [15:0] o;
        run_window(-1, 60, p, l, o);
        chk({tag, "_latency"}, longint'(l), longint'(FRAME_LAT));
        chk({tag, "_pulses"}, longint'(p), 1);
        chk({tag, "_out"}, longint'(o), longint'(exp));
        chk({tag, "_hold"}, longint'(mix_out), longint'(exp));
    endtask

    initial begin
        int p, l;
        logic signed [15:0] o;
        logic signed [15:0] exp;

        reset       = 1'b1;
        sample_tick = 1'b0;
        for (int v = 0; v < 16; v++) begin
            smp[v] = '0;
            gn[v]  = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_mix_out", longint'(mix_out), 0);
        chk("rst_mix_valid", longint'(mix_valid), 0);
        chk("rst_overrun", longint'(overrun), 0);
        chk("rst_voice_idx", longint'(voice_idx), 0);
        chk("rst_mul_start", longint'(mul_start), 0);
        chk("rst_mul_a", longint'(mul_a), 0);
        chk("rst_mul_b", longint'(mul_b), 0);
        reset = 1'b0;
        @(negedge clk);

        smp[0] = 16'sd1000;
        gn[0]  = 18'sd32768;
        do_frame("unity_v0", 16'sd1000);
        chk("no_overrun", longint'(overrun), 0);

        for (int v = 0; v < NV; v++) begin smp[v] = 16'sd30000; gn[v] = 18'sd32768; end
        do_frame("sat_pos", 16'sh7FFF);
        for (int v = 0; v < NV; v++) smp[v] = -16'sd30000;
        do_frame("sat_neg", 16'sh8000);

        for (int v = 0; v < NV; v++) gn[v] = 18'sd16384;
        smp[0] = -16'sd1; smp[1] = -16'sd1; smp[2] = 16'sd0; smp[3] = 16'sd0;
        do_frame("floor_shift", -16'sd1);

        for (int v = 0; v < NV; v++) begin smp[v] = 16'sd1234; gn[v] = '0; end
        smp[2] = 16'sd100;
        gn[2]  = -18'sd32768;
        do_frame("neg_gain", -16'sd100);

        for (int n = 0; n < 24; n++) begin
            rand_voices();
            do_frame("rand", ref_mix());
        end
        chk("no_overrun_rand", longint'(overrun), 0);

        rand_voices();
        exp = ref_mix();
        run_window(10, 60, p, l, o);
        chk("ovr_latency", longint'(l), longint'(FRAME_LAT));
        chk("ovr_pulses", longint'(p), 1);
        chk("ovr_out", longint'(o), longint'(exp));
        chk("ovr_flag", longint'(overrun), 1);
        rand_voices();
        do_frame("after_ovr", ref_mix());
        chk("ovr_sticky", longint'(overrun), 1);

        do_reset();
        chk("ovr_cleared", longint'(overrun), 0);
        rand_voices();
        exp = ref_mix();
        run_window(37, 70, p, l, o);
        chk("edge_tick_pulses", longint'(p), 1);
        chk("edge_tick_out", longint'(o), longint'(exp));
        chk("edge_tick_ovr", longint'(overrun), 1);

        // Reset during voice 2's WAIT_LO, then tick while the multiplier is still busy.
        rand_voices();
        smp[2] = 16'sd777;
        gn[2]  = 18'sd555;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (23) @(negedge clk);
        chk("pre_rst_voice_idx", longint'(voice_idx), 2);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("arst_mix_out", longint'(mix_out), 0);
        chk("arst_mix_valid", longint'(mix_valid), 0);
        chk("arst_overrun", longint'(overrun), 0);
        chk("arst_voice_idx", longint'(voice_idx), 0);
        chk("arst_mul_start", longint'(mul_start), 0);
        chk("arst_mul_a", longint'(mul_a), 0);
        chk("arst_mul_b", longint'(mul_b), 0);
        @(negedge clk);
        reset = 1'b0;
        run_window(-1, 40, p, l, o);
        chk("busy_tick_ovr", longint'(overrun), 1);
        chk("busy_tick_pulses", longint'(p), 0);
        mon_en = 1'b1;
        rand_voices();
        do_frame("post_rst", ref_mix());

        chk("protocol_violations", longint'(viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/audio_voice_mixer.md
AUDIO_VOICE_MIXER -- requirements
Module: audio_voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of voices mixed per frame (1..16).
REQ-002 SHALL have parameter GAIN_SHIFT, default 15, arithmetic right shift applied to the accumulated sum (gain 32768 = unity).
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sample_tick, input, 1, one-cycle pulse starting a mix frame.
REQ-006 SHALL have port voice_idx, output, 4, index of the voice whose sample/gain is requested.
REQ-007 SHALL have port voice_sample, input, 16 signed, sample of voice voice_idx, valid in the same cycle.
REQ-008 SHALL have port voice_gain, input, 18 signed, gain of voice voice_idx, valid in the same cycle.
REQ-009 SHALL have port mul_start, output, 1, request strobe to the 18x18 pipelined multiplier (its input_rdy).
REQ-010 SHALL have port mul_a, output, 18 signed, multiplicand (sign-extended sample).
REQ-011 SHALL have port mul_b, output, 18 signed, multiplier operand (gain).
REQ-012 SHALL have port mul_p, input, 36 signed, multiplier product.
REQ-013 SHALL have port mul_busy, input, 1, multiplier busy flag.
REQ-014 SHALL have port mix_out, output, 16 signed, saturated mixed sample.
REQ-015 SHALL have port mix_valid, output, 1, one-cycle strobe when mix_out updates.
REQ-016 SHALL have port overrun, output, 1, sticky flag: sample_tick arrived while a frame was in progress.

Function
REQ-017 SHALL implement states IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO, ACCUM, OUTPUT.
REQ-018 IDLE: on sample_tick with mul_busy low -> clear 40-bit accumulator, voice_idx=0, go LOAD; sample_tick with mul_busy high -> stay IDLE and set overrun.
REQ-019 LOAD: register mul_a = sign-extended voice_sample, mul_b = voice_gain; go ISSUE.
REQ-020 ISSUE: assert mul_start for exactly one cycle; go WAIT_HI.
REQ-021 mul_a and mul_b SHALL be held constant from LOAD until the product is captured in ACCUM (multiplier reads operand halves over several cycles).
REQ-022 WAIT_HI: wait until mul_busy=1, then go WAIT_LO; WAIT_LO: wait until mul_busy=0, then go ACCUM.
REQ-023 ACCUM: acc <= acc + sign-extended mul_p (40-bit, no wrap for NUM_VOICES<=16); if voice_idx=NUM_VOICES-1 go OUTPUT, else voice_idx+1, go LOAD.
REQ-024 OUTPUT: compute acc >>> GAIN_SHIFT (arithmetic); clamp to [-32768, 32767]; register into mix_out; pulse mix_valid one cycle; go IDLE.
REQ-025 Rounding SHALL be truncation toward negative infinity (plain arithmetic shift).
REQ-026 sample_tick in any state other than IDLE SHALL be ignored for mixing and SHALL set overrun; frame in progress completes unaffected.
REQ-027 sample_tick in the same cycle OUTPUT returns to IDLE SHALL count as overrun (not started).
REQ-028 overrun SHALL clear only on reset.
REQ-029 mix_out SHALL hold its value between mix_valid strobes.
REQ-030 mul_start SHALL never be asserted while mul_busy=1.
REQ-031 Frame latency SHALL be sample_tick to mix_valid = NUM_VOICES*(3 + multiplier busy cycles + 2) + 2 cycles; with the 5-state multiplier (busy 4 cycles) and NUM_VOICES=4: 38 cycles.

Reset
REQ-032 Reset SHALL asynchronously force state IDLE, mul_start=0, mix_valid=0, mix_out=0, overrun=0, voice_idx=0, mul_a=0, mul_b=0, acc=0.
REQ-033 Multiplier has no reset; after reset mid-operation the mixer SHALL not issue a request until mul_busy is observed low (covered by REQ-018).

Verification
REQ-034 Voice0 sample 1000 gain 32768, others gain 0; tick -> mix_out=1000, mix_valid single pulse 38 cycles after tick.
REQ-035 All four voices sample 30000 gain 32768 -> mix_out=32767 (positive saturation); all -30000 -> -32768.
REQ-036 Voice samples -1,-1,0,0 gain 16384 -> acc=-32768, mix_out=-1 (floor shift); gains -32768 with sample 100 on one voice -> -100.
REQ-037 Second sample_tick 10 cycles after first -> overrun=1, single mix_valid, result equals single-frame result; overrun persists until reset.
REQ-038 Assert reset during WAIT_LO of voice 2 -> all outputs 0 immediately; next tick issued only after mul_busy low; next frame result correct.
REQ-039 Bench checks every cycle: mul_a/mul_b stable while mul_busy=1, mul_start never high with mul_busy=1.
